// File: rtl/regfile_arbiter_pkg.sv
// Shared widths and state encoding for the two-port register file arbiter.
package regfile_arbiter_pkg;

   localparam int RA_A_WIDTH = 2;
   localparam int RA_D_WIDTH = 32;

   typedef enum logic [1:0] {
      RA_IDLE   = 2'd0,
      RA_ACCESS = 2'd1,
      RA_ACK    = 2'd2
   } ra_state_e;

endpackage

// File: rtl/regfile_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to ptr.
module regfile_arbiter_rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       gnt_id,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      gnt_id = 1'b0;
      case (req)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ptr;
         default: gnt_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises two req/ack requesters onto a 1R/1W register file, one op per 3 cycles.
//
//   state  | meaning
//   IDLE   | sample Req0/Req1, latch the winner's operands
//   ACCESS | drive RF_* from the latched op; capture read data at cycle end
//   ACK    | pulse Ack of the granted port; hand priority to the other port
module regfile_arbiter
   import regfile_arbiter_pkg::*;
#(
   parameter int A_WIDTH = RA_A_WIDTH,
   parameter int D_WIDTH = RA_D_WIDTH
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Req0,
   input  logic               Wr0,
   input  logic [A_WIDTH-1:0] Addr0,
   input  logic [D_WIDTH-1:0] WData0,
   output logic               Ack0,
   output logic [D_WIDTH-1:0] RData0,
   input  logic               Req1,
   input  logic               Wr1,
   input  logic [A_WIDTH-1:0] Addr1,
   input  logic [D_WIDTH-1:0] WData1,
   output logic               Ack1,
   output logic [D_WIDTH-1:0] RData1,
   output logic [A_WIDTH-1:0] RF_RAddr,
   output logic [A_WIDTH-1:0] RF_WAddr,
   output logic               RF_Ren,
   output logic               RF_Wen,
   output logic [D_WIDTH-1:0] RF_WData,
   input  logic [D_WIDTH-1:0] RF_RData,
   output logic               Busy
);

   ra_state_e          state_q, state_d;
   logic               ptr_q, ptr_d;
   logic               gnt_q, gnt_d;
   logic               wr_q, wr_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] wdata_q, wdata_d;
   logic [D_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [D_WIDTH-1:0] rdata1_q, rdata1_d;

   logic pick_id;
   logic pick_valid;

   regfile_arbiter_rr_pick2 u_pick (
      .req    ({Req1, Req0}),
      .ptr    (ptr_q),
      .gnt_id (pick_id),
      .valid  (pick_valid)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= RA_IDLE;
         ptr_q    <= 1'b0;
         gnt_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         RA_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_id;
               wr_d    = pick_id ? Wr1    : Wr0;
               addr_d  = pick_id ? Addr1  : Addr0;
               wdata_d = pick_id ? WData1 : WData0;
               state_d = RA_ACCESS;
            end
         end
         RA_ACCESS: begin
            // Read data is only ever taken while RF_Ren is high, so Z is never latched.
            if (!wr_q) begin
               if (gnt_q) rdata1_d = RF_RData;
               else       rdata0_d = RF_RData;
            end
            state_d = RA_ACK;
         end
         RA_ACK: begin
            ptr_d   = ~gnt_q;
            state_d = RA_IDLE;
         end
         default: state_d = RA_IDLE;
      endcase
   end

   // RF strobes decode from state and latched op only; reset drops them at once.
   always_comb begin
      RF_Ren   = 1'b0;
      RF_Wen   = 1'b0;
      RF_RAddr = '0;
      RF_WAddr = '0;
      RF_WData = '0;
      if (state_q == RA_ACCESS) begin
         if (wr_q) begin
            RF_Wen   = 1'b1;
            RF_WAddr = addr_q;
            RF_WData = wdata_q;
         end else begin
            RF_Ren   = 1'b1;
            RF_RAddr = addr_q;
         end
      end
   end

   assign Ack0   = (state_q == RA_ACK) && !gnt_q;
   assign Ack1   = (state_q == RA_ACK) &&  gnt_q;
   assign RData0 = rdata0_q;
   assign RData1 = rdata1_q;
   assign Busy   = (state_q != RA_IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed plus randomized bench for regfile_arbiter with a transaction-level model.
module tb_regfile_arbiter;

   logic        Clk;
   logic        Rst;
   logic        Req0, Wr0, Req1, Wr1;
   logic [1:0]  Addr0, Addr1;
   logic [31:0] WData0, WData1;
   logic        Ack0, Ack1;
   logic [31:0] RData0, RData1;
   logic [1:0]  RF_RAddr, RF_WAddr;
   logic        RF_Ren, RF_Wen;
   logic [31:0] RF_WData, RF_RData;
   logic        Busy;

   regfile_arbiter dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Req0     (Req0),
      .Wr0      (Wr0),
      .Addr0    (Addr0),
      .WData0   (WData0),
      .Ack0     (Ack0),
      .RData0   (RData0),
      .Req1     (Req1),
      .Wr1      (Wr1),
      .Addr1    (Addr1),
      .WData1   (WData1),
      .Ack1     (Ack1),
      .RData1   (RData1),
      .RF_RAddr (RF_RAddr),
      .RF_WAddr (RF_WAddr),
      .RF_Ren   (RF_Ren),
      .RF_Wen   (RF_Wen),
      .RF_WData (RF_WData),
      .RF_RData (RF_RData),
      .Busy     (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register file stand-in: synchronous write and clear, combinational read.
   logic [31:0] rf [4];
   always @(posedge Clk) begin
      if (Rst) for (int i = 0; i < 4; i++) rf[i] <= '0;
      else if (RF_Wen) rf[RF_WAddr] <= RF_WData;
   end
   assign RF_RData = RF_Ren ? rf[RF_RAddr] : 'z;

   int n_checks;
   int n_fail;

   // Transaction-level model of the requesters and expected results.
   bit          pend [2];
   bit          wr_a [2];
   logic [1:0]  addr_a [2];
   logic [31:0] wd_a [2];
   logic [31:0] mdl_rf [4];
   logic [31:0] mdl_rd [2];
   bit          mdl_ptr;
   bit          g;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic apply();
      Req0 = pend[0]; Wr0 = wr_a[0]; Addr0 = addr_a[0]; WData0 = wd_a[0];
      Req1 = pend[1]; Wr1 = wr_a[1]; Addr1 = addr_a[1]; WData1 = wd_a[1];
   endtask

   task automatic new_op(input int p);
      pend[p]   = 1'b1;
      wr_a[p]   = 1'($urandom_range(0, 1));
      addr_a[p] = 2'($urandom_range(0, 3));
      wd_a[p]   = $urandom;
   endtask

   task automatic set_op(input int p, input bit w, input logic [1:0] a, input logic [31:0] d);
      pend[p] = 1'b1; wr_a[p] = w; addr_a[p] = a; wd_a[p] = d;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 4; i++) mdl_rf[i] = '0;
      mdl_rd[0] = '0;
      mdl_rd[1] = '0;
      mdl_ptr   = 1'b0;
   endtask

   // Called in an IDLE cycle with requests staged; returns after the ACK-cycle checks.
   task automatic run_txn(input bit mutate, output bit gnt);
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      gnt = (pend[0] && pend[1]) ? mdl_ptr : pend[1];
      w = wr_a[gnt]; a = addr_a[gnt]; d = wd_a[gnt];
      apply();
      step();
      check("acc_busy", Busy, 1);
      check("acc_wen", RF_Wen, w);
      check("acc_ren", RF_Ren, !w);
      check("acc_waddr", RF_WAddr, w ? a : 2'd0);
      check("acc_wdata", RF_WData, w ? d : 32'd0);
      check("acc_raddr", RF_RAddr, w ? 2'd0 : a);
      check("acc_ack0", Ack0, 0);
      check("acc_ack1", Ack1, 0);
      if (mutate) begin
         Addr0 = 2'd3;
         #1;
         check("acc_raddr_hold", RF_RAddr, a);
      end
      step();
      if (w) mdl_rf[a] = d;
      else   mdl_rd[gnt] = mdl_rf[a];
      mdl_ptr   = !gnt;
      pend[gnt] = 1'b0;
      check("ack_ack0", Ack0, gnt == 1'b0);
      check("ack_ack1", Ack1, gnt == 1'b1);
      check("ack_wen", RF_Wen, 0);
      check("ack_ren", RF_Ren, 0);
      check("ack_rdata0", RData0, mdl_rd[0]);
      check("ack_rdata1", RData1, mdl_rd[1]);
   endtask

   task automatic idle_step();
      apply();
      step();
      check("idle_busy", Busy, 0);
      check("idle_ack0", Ack0, 0);
      check("idle_ack1", Ack1, 0);
      check("idle_wen", RF_Wen, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; wr_a[p] = 0; addr_a[p] = '0; wd_a[p] = '0;
      end
      reset_model();
      Rst = 1'b1;
      apply();
      #1;
      check("rst_ack0", Ack0, 0);
      check("rst_ack1", Ack1, 0);
      check("rst_rdata0", RData0, 0);
      check("rst_rdata1", RData1, 0);
      check("rst_ren", RF_Ren, 0);
      check("rst_wen", RF_Wen, 0);
      check("rst_busy", Busy, 0);
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0;

      // Port 0 write, then port 1 reads it back.
      set_op(0, 1, 2'd2, 32'hDEADBEEF);
      run_txn(0, g);
      idle_step();
      set_op(1, 0, 2'd2, 32'h0);
      run_txn(0, g);
      check("p1_read_val", RData1, 32'hDEADBEEF);
      check("p1_read_rd0", RData0, 32'h0);
      idle_step();

      // Both held: writes 1..4 to reg 0 with strict alternation.
      set_op(0, 1, 2'd0, 32'd1);
      set_op(1, 1, 2'd0, 32'd2);
      for (int k = 0; k < 4; k++) begin
         run_txn(0, g);
         check("alt_grant", g, k % 2);
         if (k < 2) begin
            pend[g] = 1'b1;
            wd_a[g] = 32'(k + 3);
         end
         idle_step();
      end
      set_op(0, 0, 2'd0, 32'h0);
      run_txn(0, g);
      check("alt_final", RData0, 32'd4);
      idle_step();

      // Back-to-back on port 0 with Req held through Ack.
      set_op(0, 1, 2'd3, 32'h5A5A5A5A);
      run_txn(0, g);
      set_op(0, 0, 2'd3, 32'h0);
      idle_step();
      run_txn(0, g);
      check("b2b_read", RData0, 32'h5A5A5A5A);
      idle_step();

      // Reset during a port 1 read ACCESS.
      set_op(1, 0, 2'd2, 32'h0);
      apply();
      step();
      check("rst_mid_ren_pre", RF_Ren, 1);
      Rst = 1'b1;
      #1;
      check("rst_mid_ren", RF_Ren, 0);
      check("rst_mid_busy", Busy, 0);
      repeat (3) begin
         step();
         check("rst_mid_ack1", Ack1, 0);
         check("rst_mid_rd1", RData1, 0);
      end
      Rst = 1'b0;
      reset_model();
      set_op(0, 1, 2'd1, 32'h11111111);
      set_op(1, 1, 2'd2, 32'h22222222);
      run_txn(0, g);
      check("post_rst_grant", g, 0);
      idle_step();
      run_txn(0, g);
      idle_step();

      // Operand change during ACCESS must not reach the register file.
      set_op(0, 0, 2'd1, 32'h0);
      run_txn(1, g);
      check("mutate_rd0", RData0, 32'h11111111);
      idle_step();

      // Randomized traffic against the model.
      for (int it = 0; it < 40; it++) begin
         for (int p = 0; p < 2; p++)
            if (!pend[p] && $urandom_range(0, 1) == 1) new_op(p);
         if (!pend[0] && !pend[1]) new_op(int'($urandom_range(0, 1)));
         run_txn(0, g);
         idle_step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
